// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle controller.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    C_R, C_IALU, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_JR, C_JALR, C_ILL
  } iclass_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FUNCT_JR   = 6'b001000;
  localparam logic [5:0] FUNCT_JALR = 6'b001001;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_RS     = 2'd3;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Datapath/memory-facing signal bundle of the multicycle controller.
interface multicycle_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       mem_ready;
  logic       mem_read;
  logic       mem_write;
  logic       i_or_d;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic [1:0] pc_src;
  logic       reg_dst;
  logic       alu_src;
  logic       mem_to_reg;
  logic       branch;
  logic       jal;
  logic       err;
  logic [2:0] state;

  modport master (
    output op, funct, mem_ready,
    input  mem_read, mem_write, i_or_d, ir_write, pc_write, reg_write,
           pc_src, reg_dst, alu_src, mem_to_reg, branch, jal, err, state
  );

  modport slave (
    input  op, funct, mem_ready,
    output mem_read, mem_write, i_or_d, ir_write, pc_write, reg_write,
           pc_src, reg_dst, alu_src, mem_to_reg, branch, jal, err, state
  );
endinterface

// File: rtl/mc_decode.sv
// Combinational op/funct -> instruction class decoder.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output iclass_e    iclass
);

  // Classify the instruction held in the IR.
  always_comb begin
    iclass = C_ILL;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FUNCT_JR:   iclass = C_JR;
          FUNCT_JALR: iclass = C_JALR;
          default:    iclass = C_R;
        endcase
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: iclass = C_IALU;
      OP_LW:   iclass = C_LW;
      OP_SW:   iclass = C_SW;
      OP_BEQ:  iclass = C_BEQ;
      OP_J:    iclass = C_J;
      OP_JAL:  iclass = C_JAL;
      default: iclass = C_ILL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM with memory wait counter and timeout.
module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  multicycle_ctrl_if.slave   bus
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  iclass_e    iclass;
  logic       timeout;

  logic       mem_read, mem_write, i_or_d, ir_write, pc_write, reg_write;
  logic [1:0] pc_src;
  logic       reg_dst, alu_src, mem_to_reg, branch, jal, err;

  mc_decode u_decode (
    .op     (bus.op),
    .funct  (bus.funct),
    .iclass (iclass)
  );

  // A ready in the limit cycle completes the access instead of timing out.
  assign timeout = (wait_cnt_q == MAX_WAIT_C) && !bus.mem_ready;

  // State and wait-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state, wait-count and control-output decode.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;  // any state change or timeout restarts the count
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    pc_src     = PC_PLUS4;
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    branch     = 1'b0;
    jal        = 1'b0;
    err        = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_IF;

      S_IF: begin
        if (bus.mem_ready) begin
          mem_read = 1'b1;
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_src   = PC_PLUS4;
          state_d  = S_ID;
        end else if (timeout) begin
          err     = 1'b1;
          state_d = S_IF;
        end else begin
          mem_read   = 1'b1;
          wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
        end
      end

      S_ID: begin
        case (iclass)
          C_J:    begin pc_write = 1'b1; pc_src = PC_JUMP; state_d = S_IF; end
          C_JAL:  begin pc_write = 1'b1; pc_src = PC_JUMP; reg_write = 1'b1; jal = 1'b1; state_d = S_IF; end
          C_JR:   begin pc_write = 1'b1; pc_src = PC_RS; state_d = S_IF; end
          C_JALR: begin pc_write = 1'b1; pc_src = PC_RS; reg_write = 1'b1; jal = 1'b1; state_d = S_IF; end
          C_ILL:  begin err = 1'b1; state_d = S_IF; end
          default: state_d = S_EX;
        endcase
      end

      S_EX: begin
        case (iclass)
          C_R:          begin reg_dst = 1'b1; state_d = S_WB; end
          C_IALU:       begin alu_src = 1'b1; state_d = S_WB; end
          C_LW, C_SW:   begin alu_src = 1'b1; state_d = S_MEM; end
          C_BEQ:        begin branch = 1'b1; pc_write = 1'b1; pc_src = PC_BRANCH; state_d = S_IF; end
          default:      state_d = S_IF;
        endcase
      end

      S_MEM: begin
        if (iclass != C_LW && iclass != C_SW) begin
          state_d = S_IF;
        end else if (timeout) begin
          err     = 1'b1;
          state_d = S_IF;
        end else begin
          i_or_d    = 1'b1;
          mem_read  = (iclass == C_LW);
          mem_write = (iclass == C_SW);
          if (bus.mem_ready) begin
            state_d = (iclass == C_LW) ? S_WB : S_IF;
          end else begin
            wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
          end
        end
      end

      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (iclass == C_R);
        mem_to_reg = (iclass == C_LW);
        state_d    = S_IF;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.mem_read   = mem_read;
  assign bus.mem_write  = mem_write;
  assign bus.i_or_d     = i_or_d;
  assign bus.ir_write   = ir_write;
  assign bus.pc_write   = pc_write;
  assign bus.reg_write  = reg_write;
  assign bus.pc_src     = pc_src;
  assign bus.reg_dst    = reg_dst;
  assign bus.alu_src    = alu_src;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.branch     = branch;
  assign bus.jal        = jal;
  assign bus.err        = err;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Cycle-by-cycle scoreboard bench for multicycle_ctrl (MAX_WAIT=4).
module tb_multicycle_ctrl;
  import mc_ctrl_pkg::*;

  // Flag bit positions in the expected/observed control word.
  localparam logic [11:0] MR  = 12'h800;
  localparam logic [11:0] MW  = 12'h400;
  localparam logic [11:0] IOD = 12'h200;
  localparam logic [11:0] IRW = 12'h100;
  localparam logic [11:0] PCW = 12'h080;
  localparam logic [11:0] RW  = 12'h040;
  localparam logic [11:0] RD  = 12'h020;
  localparam logic [11:0] AS  = 12'h010;
  localparam logic [11:0] M2R = 12'h008;
  localparam logic [11:0] BR  = 12'h004;
  localparam logic [11:0] JL  = 12'h002;
  localparam logic [11:0] ERR = 12'h001;

  typedef struct {
    string       tag;
    logic [16:0] v;
  } sb_entry_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  sb_entry_t sb_q[$];
  logic [16:0] obs;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.MAX_WAIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {bus.state, bus.pc_src, bus.mem_read, bus.mem_write, bus.i_or_d,
                bus.ir_write, bus.pc_write, bus.reg_write, bus.reg_dst, bus.alu_src,
                bus.mem_to_reg, bus.branch, bus.jal, bus.err};

  function automatic logic [16:0] ev(input logic [2:0] s, input logic [1:0] pcs,
                                     input logic [11:0] f);
    return {s, pcs, f};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Pop one expectation per cycle and compare against the live outputs.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      sb_entry_t e;
      e = sb_q.pop_front();
      check_eq(e.tag, {15'd0, obs}, {15'd0, e.v});
      check_eq({e.tag, "_rdwr_excl"}, {31'd0, bus.mem_read & bus.mem_write}, 32'd0);
    end
  end

  task automatic cyc(input string tag, input logic rst, input logic [5:0] o,
                     input logic [5:0] f, input logic rdy, input logic [16:0] e);
    @(posedge clk);
    #1;
    rst_n         = rst;
    bus.op        = o;
    bus.funct     = f;
    bus.mem_ready = rdy;
    sb_q.push_back('{tag, e});
  endtask

  task automatic fetch(input string tag, input logic [5:0] o, input logic [5:0] f);
    cyc(tag, 1'b1, o, f, 1'b1, ev(S_IF, PC_PLUS4, MR | IRW | PCW));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus.op = '0; bus.funct = '0; bus.mem_ready = 1'b1;

    // Reset held, then released; IDLE for one cycle, fetch in the second.
    cyc("rst_a",   1'b0, 6'h00, 6'h00, 1'b1, ev(S_IDLE, 2'd0, '0));
    cyc("rst_b",   1'b0, 6'h3F, 6'h3F, 1'b1, ev(S_IDLE, 2'd0, '0));
    cyc("rel_idle",1'b1, 6'h00, 6'h20, 1'b0, ev(S_IDLE, 2'd0, '0));

    // add: IF ID EX WB, mem_ready ignored outside IF/MEM
    fetch("add_if", 6'h00, 6'h20);
    cyc("add_id", 1'b1, 6'h00, 6'h20, 1'b0, ev(S_ID, 2'd0, '0));
    cyc("add_ex", 1'b1, 6'h00, 6'h20, 1'b0, ev(S_EX, 2'd0, RD));
    cyc("add_wb", 1'b1, 6'h00, 6'h20, 1'b0, ev(S_WB, 2'd0, RW | RD));

    // lw with 3 wait cycles in MEM
    fetch("lw_if", OP_LW, 6'h00);
    cyc("lw_id",  1'b1, OP_LW, 6'h00, 1'b1, ev(S_ID,  2'd0, '0));
    cyc("lw_ex",  1'b1, OP_LW, 6'h00, 1'b1, ev(S_EX,  2'd0, AS));
    cyc("lw_m0",  1'b1, OP_LW, 6'h00, 1'b0, ev(S_MEM, 2'd0, MR | IOD));
    cyc("lw_m1",  1'b1, OP_LW, 6'h00, 1'b0, ev(S_MEM, 2'd0, MR | IOD));
    cyc("lw_m2",  1'b1, OP_LW, 6'h00, 1'b0, ev(S_MEM, 2'd0, MR | IOD));
    cyc("lw_m3",  1'b1, OP_LW, 6'h00, 1'b1, ev(S_MEM, 2'd0, MR | IOD));
    cyc("lw_wb",  1'b1, OP_LW, 6'h00, 1'b0, ev(S_WB,  2'd0, RW | M2R));

    // jumps resolve in ID
    fetch("jalr_if", 6'h00, FUNCT_JALR);
    cyc("jalr_id", 1'b1, 6'h00, FUNCT_JALR, 1'b0, ev(S_ID, PC_RS, PCW | RW | JL));
    fetch("j_if", OP_J, 6'h00);
    cyc("j_id", 1'b1, OP_J, 6'h00, 1'b0, ev(S_ID, PC_JUMP, PCW));
    fetch("jal_if", OP_JAL, 6'h00);
    cyc("jal_id", 1'b1, OP_JAL, 6'h00, 1'b0, ev(S_ID, PC_JUMP, PCW | RW | JL));
    fetch("jr_if", 6'h00, FUNCT_JR);
    cyc("jr_id", 1'b1, 6'h00, FUNCT_JR, 1'b0, ev(S_ID, PC_RS, PCW));

    // beq resolves in EX
    fetch("beq_if", OP_BEQ, 6'h00);
    cyc("beq_id", 1'b1, OP_BEQ, 6'h00, 1'b0, ev(S_ID, 2'd0, '0));
    cyc("beq_ex", 1'b1, OP_BEQ, 6'h00, 1'b0, ev(S_EX, PC_BRANCH, BR | PCW));

    // I-ALU
    fetch("ori_if", OP_ORI, 6'h00);
    cyc("ori_id", 1'b1, OP_ORI, 6'h00, 1'b1, ev(S_ID, 2'd0, '0));
    cyc("ori_ex", 1'b1, OP_ORI, 6'h00, 1'b1, ev(S_EX, 2'd0, AS));
    cyc("ori_wb", 1'b1, OP_ORI, 6'h00, 1'b1, ev(S_WB, 2'd0, RW));

    // sw zero-wait
    fetch("sw_if", OP_SW, 6'h00);
    cyc("sw_id",  1'b1, OP_SW, 6'h00, 1'b0, ev(S_ID,  2'd0, '0));
    cyc("sw_ex",  1'b1, OP_SW, 6'h00, 1'b0, ev(S_EX,  2'd0, AS));
    cyc("sw_mem", 1'b1, OP_SW, 6'h00, 1'b1, ev(S_MEM, 2'd0, MW | IOD));

    // illegal opcodes
    fetch("ill_if", 6'h3F, 6'h00);
    cyc("ill_id", 1'b1, 6'h3F, 6'h00, 1'b1, ev(S_ID, 2'd0, ERR));
    fetch("ill2_if", 6'h01, 6'h00);
    cyc("ill2_id", 1'b1, 6'h01, 6'h00, 1'b0, ev(S_ID, 2'd0, ERR));

    // IF timeout after 4 wait cycles, then refetch with pc_write held off
    for (int i = 0; i < 4; i++)
      cyc("ift_wait", 1'b1, OP_J, 6'h00, 1'b0, ev(S_IF, 2'd0, MR));
    cyc("ift_err",   1'b1, OP_J, 6'h00, 1'b0, ev(S_IF, 2'd0, ERR));
    cyc("ift_refw",  1'b1, OP_J, 6'h00, 1'b0, ev(S_IF, 2'd0, MR));
    fetch("ift_refetch", OP_J, 6'h00);
    cyc("ift_j_id",  1'b1, OP_J, 6'h00, 1'b0, ev(S_ID, PC_JUMP, PCW));

    // ready in the limit cycle wins over the timeout
    for (int i = 0; i < 4; i++)
      cyc("edge_wait", 1'b1, OP_J, 6'h00, 1'b0, ev(S_IF, 2'd0, MR));
    fetch("edge_ready_wins", OP_J, 6'h00);
    cyc("edge_j_id", 1'b1, OP_J, 6'h00, 1'b0, ev(S_ID, PC_JUMP, PCW));

    // MEM timeout aborts the lw
    fetch("mt_if", OP_LW, 6'h00);
    cyc("mt_id", 1'b1, OP_LW, 6'h00, 1'b0, ev(S_ID, 2'd0, '0));
    cyc("mt_ex", 1'b1, OP_LW, 6'h00, 1'b0, ev(S_EX, 2'd0, AS));
    for (int i = 0; i < 4; i++)
      cyc("mt_wait", 1'b1, OP_LW, 6'h00, 1'b0, ev(S_MEM, 2'd0, MR | IOD));
    cyc("mt_err", 1'b1, OP_LW, 6'h00, 1'b0, ev(S_MEM, 2'd0, ERR));
    fetch("mt_next_if", OP_SW, 6'h00);

    // reset in the middle of an sw memory wait
    cyc("rs_id",   1'b1, OP_SW, 6'h00, 1'b0, ev(S_ID,  2'd0, '0));
    cyc("rs_ex",   1'b1, OP_SW, 6'h00, 1'b0, ev(S_EX,  2'd0, AS));
    cyc("rs_mem",  1'b1, OP_SW, 6'h00, 1'b0, ev(S_MEM, 2'd0, MW | IOD));
    cyc("rs_drop", 1'b0, OP_SW, 6'h00, 1'b0, ev(S_IDLE, 2'd0, '0));
    cyc("rs_idle", 1'b1, OP_SW, 6'h00, 1'b1, ev(S_IDLE, 2'd0, '0));
    fetch("rs_if", OP_SW, 6'h00);

    // drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    check_eq("sb_drained", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter MAX_WAIT, default 255: cycles a memory request may wait for mem_ready before timeout; legal range 1..255.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 op  input  6  opcode field from datapath IR; valid from ID onward.
REQ-005 funct  input  6  function field from datapath IR; valid from ID onward.
REQ-006 mem_ready  input  1  memory completion for the current request, sampled on clk.
REQ-007 mem_read, mem_write, i_or_d  output  1 each  memory request strobes; i_or_d=0 means instruction address, 1 means data address.
REQ-008 ir_write, pc_write, reg_write  output  1 each  datapath register enables.
REQ-009 pc_src  output  2  0=PC+4, 1=branch target, 2=jump target, 3=rs register.
REQ-010 reg_dst, alu_src, mem_to_reg, branch, jal  output  1 each  datapath muxes; branch means the datapath qualifies pc_write with ALU zero.
REQ-011 err  output  1  one-cycle pulse on illegal instruction or memory timeout.
REQ-012 state  output  3  encoded current state, for debug.

Function
REQ-013 The states SHALL be IDLE, IF, ID, EX, MEM, WB.
REQ-014 IDLE: all outputs 0; unconditional -> IF.
REQ-015 IF: mem_read=1, i_or_d=0; on mem_ready=1, pulse ir_write=1, pc_write=1 and pc_src=0 in that cycle, then -> ID; otherwise stay in IF.
REQ-016 ID, op=000010 (j): pc_write=1, pc_src=2; -> IF.
REQ-017 ID, op=000011 (jal): pc_write=1, pc_src=2, reg_write=1, jal=1; -> IF.
REQ-018 ID, op=0 with funct=001000 (jr): pc_write=1, pc_src=3; -> IF.
REQ-019 ID, op=0 with funct=001001 (jalr): pc_write=1, pc_src=3, reg_write=1, jal=1; -> IF.
REQ-020 ID, any other op=0, or op in {001000,001010,001100,001101,001110,000100,100011,101011}: -> EX with no enables asserted.
REQ-021 ID, any other opcode: err=1; -> IF; the PC is already advanced, so the instruction is skipped.
REQ-022 EX, R-type: reg_dst=1, alu_src=0; -> WB.
REQ-023 EX, I-ALU: alu_src=1; -> WB.
REQ-024 EX, lw/sw: alu_src=1; -> MEM.
REQ-025 EX, beq: branch=1, pc_write=1, pc_src=1; -> IF.
REQ-026 MEM: i_or_d=1; mem_read=1 for lw, mem_write=1 for sw, held until mem_ready.
REQ-027 MEM on mem_ready=1: lw -> WB; sw -> IF.
REQ-028 WB: reg_write=1; reg_dst=1 for R-type; mem_to_reg=1 for lw; -> IF.
REQ-029 Latency from IF entry with zero-wait memory: j/jal/jr/jalr 2 cycles; beq 3; R, I-ALU and sw 4; lw 5.
REQ-030 Each wait state adds one cycle.
REQ-031 A wait counter SHALL clear on entering IF or MEM and increment each cycle mem_ready=0.
REQ-032 When the wait counter reaches MAX_WAIT: err=1, drop the request, and go -> IF. An IF timeout re-fetches with the PC unchanged; a MEM timeout aborts the instruction.
REQ-033 If mem_ready=1 in the same cycle the counter reaches MAX_WAIT, mem_ready SHALL win and no err is raised.
REQ-034 The counter SHALL be 8 bits and saturate, never wrap.
REQ-035 mem_ready SHALL be ignored in ID, EX, WB and IDLE.
REQ-036 Outputs SHALL be Moore/Mealy functions of the registered state, op, funct and mem_ready only.
REQ-037 mem_read and mem_write SHALL never be asserted together.

Reset
REQ-038 On rst_n=0, state SHALL become IDLE and the wait counter 0 immediately, including mid-instruction or mid-wait.
REQ-039 While rst_n=0, all outputs SHALL be 0.
REQ-040 The first fetch SHALL be issued in the second cycle after rst_n deasserts.

Structure
REQ-041 Package mc_ctrl_pkg SHALL hold the state enum, opcode/funct constants, pc_src codes and the instruction-class enum (R, IALU, LW, SW, BEQ, J, JAL, JR, JALR, ILL).
REQ-042 A combinational sub-module mc_decode SHALL map op/funct to an instruction class.
REQ-043 The FSM, wait counter and output decode SHALL reside in multicycle_ctrl.

Verification
REQ-044 Reset then add (op=0, funct=100000), mem_ready tied 1 -> states IDLE, IF, ID, EX, WB, IF; reg_write=1 with reg_dst=1 in WB only.
REQ-045 lw (op=100011) with 3 wait cycles in MEM -> mem_read held 4 cycles with i_or_d=1; WB with mem_to_reg=1; total 8 cycles.
REQ-046 jalr (op=0, funct=001001) -> in ID: pc_write=1, pc_src=3, reg_write=1, jal=1; next state IF; no EX.
REQ-047 op=111111 -> err pulses 1 cycle in ID; no reg_write or mem strobe; next state IF.
REQ-048 MAX_WAIT=4, mem_ready held 0 in IF -> err after 4 wait cycles; the IF refetch has pc_write=0 until the subsequent mem_ready.
REQ-049 rst_n pulsed low mid-MEM of sw -> mem_write drops in the same cycle; IDLE then IF; no err.
